// File: rtl/uart_rx_frame_ctrl.sv
// Frame controller behind the UART byte receiver: SYNC hunt, LEN/payload parsing, frame buffer and host handshake.
// Optional checksum byte and its checking are enabled by defining RX_FRAME_CSUM_EN.
module uart_rx_frame_ctrl #(
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter int unsigned MAX_LEN     = 16,
    parameter int unsigned TIMEOUT_CYC = 52080,
    parameter int unsigned TO_W        = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [7:0]                     rx_data,
    input  logic                           rx_done,
    output logic                           frame_valid,
    input  logic                           frame_ready,
    output logic [$clog2(MAX_LEN+1)-1:0]   frame_len,
    input  logic [$clog2(MAX_LEN)-1:0]     rd_addr,
    output logic [7:0]                     rd_data,
    output logic                           busy,
    output logic                           err_len,
    output logic                           err_csum,
    output logic                           err_timeout,
    output logic                           ovr
);

    localparam int unsigned LEN_W  = $clog2(MAX_LEN + 1);
    localparam int unsigned ADDR_W = $clog2(MAX_LEN);

`ifdef RX_FRAME_CSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CSUM, S_HOLD} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_LEN, S_PAYLOAD, S_HOLD} state_t;
`endif

    state_t              state_q, state_d;
    logic                rx_done_d;
    logic                accept;
    logic                in_frame;
    logic                last_byte;
    logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic                wr_en;
    logic [7:0]          mem [MAX_LEN];

    logic                frame_valid_d, busy_d, err_len_d, err_timeout_d, ovr_d;
    logic [LEN_W-1:0]    frame_len_d;

`ifdef RX_FRAME_CSUM_EN
    logic [7:0]          csum_q, csum_d;
    logic                err_csum_d;
`endif

    // One byte per rising edge of rx_done, however long the strobe stays high
    assign accept = rx_done & ~rx_done_d;

    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        idx_d         = idx_q;
        to_cnt_d      = '0;
        wr_en         = 1'b0;
        err_len_d     = 1'b0;
        err_timeout_d = 1'b0;
        ovr_d         = 1'b0;
`ifdef RX_FRAME_CSUM_EN
        csum_d        = csum_q;
        err_csum_d    = 1'b0;
        in_frame      = (state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CSUM);
`else
        in_frame      = (state_q == S_LEN) || (state_q == S_PAYLOAD);
`endif
        last_byte     = (LEN_W'(idx_q) == (len_q - LEN_W'(1)));

        case (state_q)
            S_IDLE: begin
                if (accept && (rx_data == SYNC_BYTE)) state_d = S_LEN;
            end
            S_LEN: begin
                if (accept) begin
                    if ((rx_data == 8'h00) || (rx_data > 8'(MAX_LEN))) begin
                        err_len_d = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        len_d   = LEN_W'(rx_data);
                        idx_d   = '0;
`ifdef RX_FRAME_CSUM_EN
                        csum_d  = rx_data;
`endif
                        state_d = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (accept) begin
                    wr_en  = 1'b1;
                    idx_d  = idx_q + ADDR_W'(1);
`ifdef RX_FRAME_CSUM_EN
                    csum_d = csum_q ^ rx_data;
                    if (last_byte) state_d = S_CSUM;
`else
                    if (last_byte) state_d = S_HOLD;
`endif
                end
            end
`ifdef RX_FRAME_CSUM_EN
            S_CSUM: begin
                if (accept) begin
                    if (rx_data == csum_q) begin
                        state_d = S_HOLD;
                    end else begin
                        err_csum_d = 1'b1;
                        state_d    = S_IDLE;
                    end
                end
            end
`endif
            S_HOLD: begin
                if (accept) ovr_d = 1'b1;
                if (frame_valid && frame_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Inter-byte watchdog; an accept in the expiry cycle takes precedence
        if (in_frame && !accept) begin
            if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
                err_timeout_d = 1'b1;
                state_d       = S_IDLE;
            end else begin
                to_cnt_d = to_cnt_q + TO_W'(1);
            end
        end

        frame_valid_d = (state_d == S_HOLD);
        frame_len_d   = (state_d == S_HOLD) ? len_d : '0;
`ifdef RX_FRAME_CSUM_EN
        busy_d        = (state_d == S_LEN) || (state_d == S_PAYLOAD) || (state_d == S_CSUM);
`else
        busy_d        = (state_d == S_LEN) || (state_d == S_PAYLOAD);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rx_done_d   <= 1'b0;
            to_cnt_q    <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            frame_valid <= 1'b0;
            frame_len   <= '0;
            busy        <= 1'b0;
            err_len     <= 1'b0;
            err_timeout <= 1'b0;
            ovr         <= 1'b0;
        end else begin
            state_q     <= state_d;
            rx_done_d   <= rx_done;
            to_cnt_q    <= to_cnt_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            frame_valid <= frame_valid_d;
            frame_len   <= frame_len_d;
            busy        <= busy_d;
            err_len     <= err_len_d;
            err_timeout <= err_timeout_d;
            ovr         <= ovr_d;
        end
    end

`ifdef RX_FRAME_CSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q   <= '0;
            err_csum <= 1'b0;
        end else begin
            csum_q   <= csum_d;
            err_csum <= err_csum_d;
        end
    end
`else
    assign err_csum = 1'b0;
`endif

    // Payload buffer keeps its contents across reset
    always_ff @(posedge clk) begin
        if (wr_en) mem[idx_q] <= rx_data;
    end

    assign rd_data = (LEN_W'(rd_addr) < frame_len) ? mem[rd_addr] : 8'h00;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Self-checking bench for uart_rx_frame_ctrl: directed scenarios plus randomized frames against a frame-level model.
// Honours RX_FRAME_CSUM_EN the same way as the design.
module tb_uart_rx_frame_ctrl;

    localparam int unsigned MAX_LEN     = 16;
    localparam int unsigned TIMEOUT_CYC = 200;
    localparam int unsigned TO_W        = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done = 1'b0;
    logic       frame_valid;
    logic       frame_ready = 1'b0;
    logic [4:0] frame_len;
    logic [3:0] rd_addr = 4'd0;
    logic [7:0] rd_data;
    logic       busy, err_len, err_csum, err_timeout, ovr;

    int cmp = 0;
    int mis = 0;
    int n_len = 0, n_csum = 0, n_to = 0, n_ovr = 0, n_multi = 0;
    int b_len, b_csum, b_to, b_ovr;
    logic [7:0] pl[$];

    always #5 clk = ~clk;

    uart_rx_frame_ctrl #(
        .SYNC_BYTE(8'hA5), .MAX_LEN(MAX_LEN), .TIMEOUT_CYC(TIMEOUT_CYC), .TO_W(TO_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_done(rx_done),
        .frame_valid(frame_valid), .frame_ready(frame_ready), .frame_len(frame_len),
        .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .err_len(err_len),
        .err_csum(err_csum), .err_timeout(err_timeout), .ovr(ovr)
    );

    // Pulse counters: a correct 1-cycle pulse adds exactly one
    always @(negedge clk) begin
        if (rst_n) begin
            n_len  += int'(err_len);
            n_csum += int'(err_csum);
            n_to   += int'(err_timeout);
            n_ovr  += int'(ovr);
            if (int'(err_len) + int'(err_csum) + int'(err_timeout) > 1) n_multi++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic snap();
        b_len = n_len; b_csum = n_csum; b_to = n_to; b_ovr = n_ovr;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic release_frame();
        @(negedge clk);
        frame_ready = 1'b1;
        @(negedge clk);
        frame_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [10:0] outs;
        repeat (3) @(negedge clk);
        outs = {frame_valid, busy, err_len, err_csum, err_timeout, ovr, frame_len};
        cmp++;
        if (outs !== 11'd0) begin mis++; $display("FAIL reset_outputs_in_reset: got %h want 000", outs); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        outs = {frame_valid, busy, err_len, err_csum, err_timeout, ovr, frame_len};
        cmp++;
        if (outs !== 11'd0) begin mis++; $display("FAIL reset_outputs_after: got %h want 000", outs); end
        cmp++;
        if (rd_data !== 8'h00) begin mis++; $display("FAIL reset_rd_data: got %h want 00", rd_data); end
    endtask

    task automatic test_spec_frames();
        logic [7:0] exp_rd [4];
        exp_rd = '{8'h11, 8'h22, 8'h33, 8'h00};
        snap();
        send_byte(8'hA5, 1); send_byte(8'h03, 0); send_byte(8'h11, 2);
        send_byte(8'h22, 0); send_byte(8'h33, 1);
`ifdef RX_FRAME_CSUM_EN
        send_byte(8'h03, 0);
`endif
        @(negedge clk);
        cmp++;
        if (frame_valid !== 1'b1) begin mis++; $display("FAIL spec1_valid: got %b want 1", frame_valid); end
        cmp++;
        if (frame_len !== 5'd3) begin mis++; $display("FAIL spec1_len: got %0d want 3", frame_len); end
        for (int a = 0; a < 4; a++) begin
            rd_addr = 4'(a);
            #2;
            cmp++;
            if (rd_data !== exp_rd[a]) begin mis++; $display("FAIL spec1_rd[%0d]: got %h want %h", a, rd_data, exp_rd[a]); end
        end
        release_frame();
        cmp++;
        if (frame_valid !== 1'b0) begin mis++; $display("FAIL spec1_release: got %b want 0", frame_valid); end
`ifdef RX_FRAME_CSUM_EN
        snap();
        send_byte(8'hA5, 0); send_byte(8'h03, 0); send_byte(8'h11, 0);
        send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h04, 0);
        @(negedge clk);
        cmp++;
        if ((n_csum - b_csum) != 1 || frame_valid !== 1'b0)
            begin mis++; $display("FAIL spec2_csum_err: got pulses=%0d valid=%b want 1/0", n_csum - b_csum, frame_valid); end
        send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h5A, 0); send_byte(8'h5B, 0);
`else
        send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h5A, 0);
`endif
        @(negedge clk);
        rd_addr = 4'd0;
        #2;
        cmp++;
        if ({frame_valid, frame_len, rd_data} !== {1'b1, 5'd1, 8'h5A})
            begin mis++; $display("FAIL spec2_good: got v=%b len=%0d d=%h want 1/1/5a", frame_valid, frame_len, rd_data); end
        release_frame();
    endtask

    task automatic test_len_errors();
        logic [7:0] x;
        snap();
        send_byte(8'hA5, 0); send_byte(8'h00, 0);
        @(negedge clk);
        cmp++;
        if ((n_len - b_len) != 1 || busy !== 1'b0)
            begin mis++; $display("FAIL len_zero: got pulses=%0d busy=%b want 1/0", n_len - b_len, busy); end
        send_byte(8'hA5, 0); send_byte(8'h11, 0);
        @(negedge clk);
        cmp++;
        if ((n_len - b_len) != 2 || busy !== 1'b0 || frame_valid !== 1'b0)
            begin mis++; $display("FAIL len_over: got pulses=%0d busy=%b want 2/0", n_len - b_len, busy); end
        // Largest legal length fills the whole buffer
        send_byte(8'hA5, 0); send_byte(8'h10, 0);
        x = 8'h10;
        for (int i = 0; i < 16; i++) begin
            send_byte(8'(i * 17), 0);
            x ^= 8'(i * 17);
        end
`ifdef RX_FRAME_CSUM_EN
        send_byte(x, 0);
`endif
        @(negedge clk);
        rd_addr = 4'd15;
        #2;
        cmp++;
        if ({frame_valid, frame_len, rd_data} !== {1'b1, 5'd16, 8'hFF})
            begin mis++; $display("FAIL len_max: got v=%b len=%0d d15=%h want 1/16/ff", frame_valid, frame_len, rd_data); end
        release_frame();
    endtask

    task automatic test_timeout();
        int first;
        logic busy_pre;
        snap();
        first = -1;
        busy_pre = 1'b0;
        send_byte(8'hA5, 0); send_byte(8'h02, 0); send_byte(8'h7E, 0);
        for (int k = 1; k <= int'(TIMEOUT_CYC) + 5; k++) begin
            @(negedge clk);
            if (k == int'(TIMEOUT_CYC) - 1) busy_pre = busy;
            if (err_timeout === 1'b1 && first < 0) first = k;
        end
        cmp++;
        if (first != int'(TIMEOUT_CYC))
            begin mis++; $display("FAIL timeout_cycle: got %0d want %0d", first, TIMEOUT_CYC); end
        cmp++;
        if ({busy_pre, busy} !== 2'b10 || (n_to - b_to) != 1)
            begin mis++; $display("FAIL timeout_state: got busy %b%b pulses=%0d want 10/1", busy_pre, busy, n_to - b_to); end
        // A byte landing in the expiry cycle must win
        snap();
        send_byte(8'hA5, 0); send_byte(8'h02, 0);
        repeat (TIMEOUT_CYC - 1) @(negedge clk);
        rx_data = 8'h31;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        cmp++;
        if ((n_to - b_to) != 0 || busy !== 1'b1)
            begin mis++; $display("FAIL timeout_accept_wins: got pulses=%0d busy=%b want 0/1", n_to - b_to, busy); end
        send_byte(8'h32, 0);
`ifdef RX_FRAME_CSUM_EN
        send_byte(8'h01, 0);
`endif
        @(negedge clk);
        cmp++;
        if ({frame_valid, frame_len} !== {1'b1, 5'd2})
            begin mis++; $display("FAIL timeout_recover: got v=%b len=%0d want 1/2", frame_valid, frame_len); end
        release_frame();
    endtask

    task automatic test_overrun();
        send_byte(8'hA5, 0); send_byte(8'h02, 0); send_byte(8'hC3, 0); send_byte(8'hA5, 0);
`ifdef RX_FRAME_CSUM_EN
        send_byte(8'h64, 0);
`endif
        @(negedge clk);
        snap();
        send_byte(8'h44, 1);
        rd_addr = 4'd1;
        #2;
        cmp++;
        if ((n_ovr - b_ovr) != 1 || {frame_valid, frame_len, rd_data} !== {1'b1, 5'd2, 8'hA5})
            begin mis++; $display("FAIL ovr_hold: got pulses=%0d v=%b len=%0d d1=%h want 1/1/2/a5", n_ovr - b_ovr, frame_valid, frame_len, rd_data); end
        // Byte arriving in the handshake cycle is dropped too, even a SYNC
        @(negedge clk);
        frame_ready = 1'b1;
        rx_data = 8'hA5;
        rx_done = 1'b1;
        @(negedge clk);
        frame_ready = 1'b0;
        rx_done = 1'b0;
        @(negedge clk);
        cmp++;
        if ((n_ovr - b_ovr) != 2 || frame_valid !== 1'b0 || busy !== 1'b0)
            begin mis++; $display("FAIL ovr_handshake: got pulses=%0d v=%b busy=%b want 2/0/0", n_ovr - b_ovr, frame_valid, busy); end
    endtask

    task automatic test_held_done_and_reset();
        logic [10:0] outs;
        snap();
        @(negedge clk);
        rx_data = 8'hA5;
        rx_done = 1'b1;
        repeat (5) @(negedge clk);
        rx_done = 1'b0;
        @(negedge clk);
        cmp++;
        if (busy !== 1'b1 || (n_len - b_len) != 0)
            begin mis++; $display("FAIL held_done_single: got busy=%b err_len=%0d want 1/0", busy, n_len - b_len); end
        send_byte(8'h04, 0); send_byte(8'hAA, 0); send_byte(8'hBB, 0);
        #2;
        rst_n = 1'b0;
        #1;
        outs = {frame_valid, busy, err_len, err_csum, err_timeout, ovr, frame_len};
        cmp++;
        if (outs !== 11'd0) begin mis++; $display("FAIL async_reset: got %h want 000", outs); end
        @(negedge clk);
        rst_n = 1'b1;
        send_byte(8'hCC, 0); send_byte(8'hDD, 0); send_byte(8'h04, 0);
        @(negedge clk);
        cmp++;
        if ({frame_valid, busy} !== 2'b00)
            begin mis++; $display("FAIL reset_discard: got v=%b busy=%b want 0/0", frame_valid, busy); end
    endtask

    task automatic test_random();
        int len, kind, exp_kind, nnoise;
        logic [7:0] x, cs, b;
        logic [3:0] d_obs, d_exp;
        for (int it = 0; it < 60; it++) begin
            pl.delete();
            kind = $urandom_range(0, 9);
            if (kind < 2) len = (kind == 0) ? 0 : $urandom_range(MAX_LEN + 1, 255);
            else          len = $urandom_range(1, MAX_LEN);
            if (len >= 1 && len <= int'(MAX_LEN))
                for (int i = 0; i < len; i++)
                    pl.push_back(($urandom_range(0, 5) == 0) ? 8'hA5 : 8'($urandom_range(0, 255)));
            x = 8'(len);
            foreach (pl[i]) x ^= pl[i];
            cs = x;
`ifdef RX_FRAME_CSUM_EN
            if (kind == 2 || kind == 3) cs = x ^ 8'($urandom_range(1, 255));
`endif
            // Frame-level model: length rule first, then checksum rule
            if (len == 0 || len > int'(MAX_LEN)) exp_kind = 1;
            else if (cs != x)                    exp_kind = 2;
            else                                 exp_kind = 0;

            snap();
            nnoise = $urandom_range(0, 2);
            for (int i = 0; i < nnoise; i++) begin
                b = 8'($urandom_range(0, 255));
                send_byte((b == 8'hA5) ? 8'h00 : b, $urandom_range(0, 3));
            end
            send_byte(8'hA5, $urandom_range(0, 3));
            send_byte(8'(len), $urandom_range(0, 3));
            foreach (pl[i]) send_byte(pl[i], $urandom_range(0, 3));
`ifdef RX_FRAME_CSUM_EN
            if (exp_kind != 1) send_byte(cs, $urandom_range(0, 3));
`endif
            @(negedge clk);
            d_obs = {4'(n_len - b_len), 4'(0)} == 8'h0 ? 4'h0 : 4'h0;
            d_obs = {n_len - b_len == 1, n_csum - b_csum == 1, n_to != b_to, n_ovr != b_ovr};
            d_exp = {exp_kind == 1, exp_kind == 2, 1'b0, 1'b0};
            cmp++;
            if (d_obs !== d_exp || (n_len - b_len) > 1 || (n_csum - b_csum) > 1)
                begin mis++; $display("FAIL rand%0d_errors: got %b want %b (len=%0d)", it, d_obs, d_exp, len); end
            cmp++;
            if (frame_valid !== (exp_kind == 0) || busy !== 1'b0)
                begin mis++; $display("FAIL rand%0d_valid: got v=%b busy=%b want %b/0", it, frame_valid, busy, exp_kind == 0); end
            if (exp_kind == 0) begin
                cmp++;
                if (frame_len !== 5'(len)) begin mis++; $display("FAIL rand%0d_len: got %0d want %0d", it, frame_len, len); end
                for (int a = 0; a < 16; a++) begin
                    rd_addr = 4'(a);
                    #2;
                    b = (a < len) ? pl[a] : 8'h00;
                    cmp++;
                    if (rd_data !== b) begin mis++; $display("FAIL rand%0d_rd[%0d]: got %h want %h", it, a, rd_data, b); end
                end
                release_frame();
                cmp++;
                if (frame_valid !== 1'b0) begin mis++; $display("FAIL rand%0d_release: got %b want 0", it, frame_valid); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_spec_frames();
        test_len_errors();
        test_timeout();
        test_overrun();
        test_held_done_and_reset();
        test_random();
        cmp++;
        if (n_multi != 0) begin mis++; $display("FAIL err_exclusive: got %0d overlaps want 0", n_multi); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
        $finish;
    end

endmodule
